// File: rtl/dac_spi_serializer_if.sv
// Sample-strobe and DAC SPI bus bundle for dac_spi_serializer.
// o_overrun_cnt exists only when DAC_OVERRUN_CNT_EN is defined.
interface dac_spi_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ce;
  logic                  o_cs_n;
  logic                  o_sclk;
  logic                  o_mosi;
  logic                  o_busy;
  logic                  o_done;
`ifdef DAC_OVERRUN_CNT_EN
  logic [7:0]            o_overrun_cnt;
`endif

  modport master (
    output i_data,
    output i_ce,
    input  o_cs_n,
    input  o_sclk,
    input  o_mosi,
    input  o_busy,
    input  o_done
`ifdef DAC_OVERRUN_CNT_EN
    ,
    input  o_overrun_cnt
`endif
  );

  modport slave (
    input  i_data,
    input  i_ce,
    output o_cs_n,
    output o_sclk,
    output o_mosi,
    output o_busy,
    output o_done
`ifdef DAC_OVERRUN_CNT_EN
    ,
    output o_overrun_cnt
`endif
  );
endinterface

// File: rtl/dac_spi_serializer.sv
// SPI mode-0 DAC serializer with a one-deep pending sample buffer.
// Define DAC_OVERRUN_CNT_EN to add the saturating o_overrun_cnt output.
module dac_spi_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input logic                 clk,
  input logic                 rst,
  dac_spi_serializer_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] SHIFT_LO = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  localparam int               BIT_W     = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  // 9 bits covers the longest interval, the gap of 2*255 cycles
  localparam logic [8:0]       HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0]       GAP_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]       DIV_ONE   = 9'd1;

  logic [2:0]            state;
  logic [8:0]            div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_vld;
  logic                  cs_n_r;
  logic                  sclk_r;
  logic                  mosi_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  half_end;
  logic                  gap_end;
  logic                  ce_busy;
  logic                  start_frame;
  logic                  shift_now;
  logic [DATA_WIDTH-1:0] start_data;

  // A frame starts from IDLE on a strobe, or at the end of the gap from the
  // pending buffer (or from a strobe landing exactly then with nothing pending).
  always_comb begin
    half_end    = (div_cnt == HALF_LAST);
    gap_end     = (state == GAP) && (div_cnt == GAP_LAST);
    ce_busy     = bus.i_ce && (state != IDLE);
    start_frame = ((state == IDLE) && bus.i_ce) || (gap_end && (pend_vld || bus.i_ce));
    start_data  = (gap_end && pend_vld) ? pend_data : bus.i_data;
    shift_now   = (state == SHIFT_HI) && half_end && (bit_cnt != BIT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      cs_n_r   <= 1'b1;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start_frame) begin
        state   <= SETUP;
        div_cnt <= '0;
        bit_cnt <= '0;
        cs_n_r  <= 1'b0;
        sclk_r  <= 1'b0;
        busy_r  <= 1'b1;
        mosi_r  <= start_data[DATA_WIDTH-1];
      end else begin
        case (state)
          IDLE: ;
          SETUP: begin
            if (half_end) begin
              state   <= SHIFT_HI;
              sclk_r  <= 1'b1;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
          SHIFT_HI: begin
            if (half_end) begin
              state   <= SHIFT_LO;
              sclk_r  <= 1'b0;
              div_cnt <= '0;
              if (shift_now) mosi_r <= shift_reg[DATA_WIDTH-2];
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
          SHIFT_LO: begin
            if (half_end) begin
              div_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                state  <= GAP;
                cs_n_r <= 1'b1;
                done_r <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
                state   <= SHIFT_HI;
                sclk_r  <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
          GAP: begin
            if (gap_end) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              div_cnt <= div_cnt + DIV_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // At gap end the buffer keeps its fill state: a pending sample is
      // replaced by the new strobe, an empty one stays empty (strobe starts).
      if (ce_busy && !gap_end)
        pend_vld <= 1'b1;
      else if (gap_end && pend_vld && !bus.i_ce)
        pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_frame)
      shift_reg <= start_data;
    else if (shift_now)
      shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
    if (ce_busy && (!gap_end || pend_vld))
      pend_data <= bus.i_data;
  end

`ifdef DAC_OVERRUN_CNT_EN
  logic       overrun_evt;
  logic [7:0] overrun_cnt;

  assign overrun_evt = ce_busy && !gap_end && pend_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun_cnt <= 8'd0;
    else if (overrun_evt && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  assign bus.o_overrun_cnt = overrun_cnt;
`endif

  assign bus.o_cs_n = cs_n_r;
  assign bus.o_sclk = sclk_r;
  assign bus.o_mosi = mosi_r;
  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;
endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: frame scoreboard, vector table, corner sequences.
module tb_dac_spi_serializer;
  localparam int DW      = 16;
  localparam int EXP_LOW = 4 * (1 + 2 * DW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dac_spi_serializer_if #(.DATA_WIDTH(DW)) bus ();
  dac_spi_serializer_if #(.DATA_WIDTH(DW)) bus1 ();

  dac_spi_serializer #(.DATA_WIDTH(DW), .CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  dac_spi_serializer #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  bit          sb_en = 1'b1;

  int          cyc = 0;
  int          mon_low = 0;
  int          mon_edges = 0;
  int          rise_cyc = 0;
  int          gap_to_start = 0;
  int          done_cnt = 0;
  int          frames = 0;
  logic [15:0] mon_bits = '0;
  logic [15:0] exp_word;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_mosi = 1'b0;

  // Frame monitor on the CLK_DIV=4 instance, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_busy = 1'b0;
      prev_mosi = 1'b0;
      mon_low   = 0;
      mon_edges = 0;
    end else begin
      if (prev_cs && !bus.o_cs_n) begin
        mon_low      = 0;
        mon_edges    = 0;
        mon_bits     = '0;
        gap_to_start = cyc - rise_cyc;
      end
      if (!bus.o_cs_n) begin
        mon_low++;
        if (bus.o_sclk && !prev_sclk) begin
          mon_bits = {mon_bits[14:0], bus.o_mosi};
          mon_edges++;
        end
        if (bus.o_sclk && prev_sclk && (bus.o_mosi !== prev_mosi))
          check("mosi_stable_while_sclk_high", bus.o_mosi, prev_mosi);
      end
      if (bus.o_done) begin
        done_cnt++;
        check("done_only_at_cs_rise", {prev_cs, bus.o_cs_n}, 2'b01);
      end
      if (!prev_cs && bus.o_cs_n) begin
        rise_cyc = cyc;
        frames++;
        check("cs_low_cycles", mon_low, EXP_LOW);
        check("sclk_rising_edges", mon_edges, DW);
        check("done_with_cs_rise", bus.o_done, 1'b1);
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            exp_word = exp_q.pop_front();
            check("frame_data", mon_bits, exp_word);
          end
        end
      end
      if (prev_busy && !bus.o_busy)
        check("busy_tail_after_cs_rise", cyc - rise_cyc, 8);
      prev_cs   = bus.o_cs_n;
      prev_sclk = bus.o_sclk;
      prev_busy = bus.o_busy;
      prev_mosi = bus.o_mosi;
    end
  end

  task automatic strobe(input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.i_data = d;
    bus.i_ce   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ce   = 1'b0;
  endtask

  task automatic strobe1(input logic [15:0] d);
    @(posedge clk);
    #1;
    bus1.i_data = d;
    bus1.i_ce   = 1'b1;
    @(posedge clk);
    #1;
    bus1.i_ce   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((bus.o_busy || (exp_q.size() != 0)) && (n < max)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_reached"}, (n < max), 1'b1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_word;
    int          exp_low;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_before;
    int   frames_before;
    int   n;
    int   low1;
    int   edges1;
    int   r1;
    int   r2;
    logic ps1;
    logic [15:0] b1;
    logic [15:0] d;

    vecs = '{
      '{16'hA5C3, 16'hA5C3, 132},
      '{16'h0000, 16'h0000, 132},
      '{16'hFFFF, 16'hFFFF, 132},
      '{16'h8001, 16'h8001, 132},
      '{16'h5555, 16'h5555, 132},
      '{16'h0001, 16'h0001, 132}
    };

    bus.i_ce = 1'b0;
    bus.i_data = '0;
    bus1.i_ce = 1'b0;
    bus1.i_data = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", bus.o_cs_n, 1'b1);
    check("rst_sclk", bus.o_sclk, 1'b0);
    check("rst_mosi", bus.o_mosi, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
`ifdef DAC_OVERRUN_CNT_EN
    check("rst_overrun_cnt", bus.o_overrun_cnt, 8'd0);
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single frames from IDLE
    for (int i = 0; i < 6; i++) begin
      frames_before = frames;
      exp_q.push_back(vecs[i].exp_word);
      strobe(vecs[i].data);
      wait_idle("table", 400);
      check("table_frame_count", frames - frames_before, 1);
      check("table_low_cycles", mon_low, vecs[i].exp_low);
    end

    // Back-to-back: second sample waits in the pending buffer
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hFFFF);
    strobe(16'h1234);
    repeat (20) @(posedge clk);
    strobe(16'hFFFF);
    wait_idle("b2b", 600);
    check("b2b_gap_cycles", gap_to_start, 8);
`ifdef DAC_OVERRUN_CNT_EN
    check("b2b_overrun_cnt", bus.o_overrun_cnt, 8'd0);
`endif

    // Overrun: latest pending sample wins
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0003);
    strobe(16'h0001);
    repeat (10) @(posedge clk);
    strobe(16'h0002);
    repeat (5) @(posedge clk);
    strobe(16'h0003);
    wait_idle("overrun", 600);
`ifdef DAC_OVERRUN_CNT_EN
    check("overrun_cnt_one", bus.o_overrun_cnt, 8'd1);
`endif

    // Continuous strobing: counter saturates, last sample is the last frame
    sb_en = 1'b0;
    @(posedge clk);
    #1;
    bus.i_ce = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.i_data = 16'(i);
      @(posedge clk);
      #1;
    end
    bus.i_ce = 1'b0;
    wait_idle("saturate", 2000);
    check("saturate_last_frame", mon_bits, 16'd399);
`ifdef DAC_OVERRUN_CNT_EN
    check("overrun_cnt_saturated", bus.o_overrun_cnt, 8'd255);
`endif
    sb_en = 1'b1;

    // Reset in the middle of a frame
    strobe(16'h7E81);
    n = 0;
    while ((mon_edges < 7) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check("midframe_reached_bit7", (n < 500), 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_before = done_cnt;
    #1;
    check("midrst_cs_n", bus.o_cs_n, 1'b1);
    check("midrst_sclk", bus.o_sclk, 1'b0);
    check("midrst_mosi", bus.o_mosi, 1'b0);
    check("midrst_busy", bus.o_busy, 1'b0);
    check("midrst_done", bus.o_done, 1'b0);
`ifdef DAC_OVERRUN_CNT_EN
    check("midrst_overrun_cnt", bus.o_overrun_cnt, 8'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    check("midrst_no_done", done_cnt, done_before);
    check("midrst_stays_idle", bus.o_cs_n, 1'b1);
    exp_q.push_back(16'h8001);
    strobe(16'h8001);
    wait_idle("after_reset", 400);

    // CLK_DIV=1 instance
    strobe1(16'h8000);
    low1 = 0;
    edges1 = 0;
    r1 = -1;
    r2 = -1;
    ps1 = 1'b0;
    b1 = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus1.o_cs_n) begin
        low1++;
        if (bus1.o_sclk && !ps1) begin
          b1 = {b1[14:0], bus1.o_mosi};
          edges1++;
          if (edges1 == 1) r1 = k;
          if (edges1 == 2) r2 = k;
        end
      end
      ps1 = bus1.o_sclk;
    end
    check("div1_cs_low_cycles", low1, 33);
    check("div1_sclk_edges", edges1, 16);
    check("div1_sclk_period", r2 - r1, 2);
    check("div1_frame_data", b1, 16'h8000);
    check("div1_idle_after", bus1.o_busy, 1'b0);

    // Sine-controller style stream: one strobe every 150 cycles
    frames_before = frames;
    for (int i = 0; i < 256; i++) begin
      check("stream_no_overlap", {bus.o_busy, bus.o_cs_n}, 2'b01);
      d = 16'(32768 + ((i * 1237) % 20000) - 10000);
      exp_q.push_back(d);
      strobe(d);
      repeat (148) @(posedge clk);
    end
    wait_idle("stream", 400);
    check("stream_frame_count", frames - frames_before, 256);
`ifdef DAC_OVERRUN_CNT_EN
    check("stream_overrun_cnt", bus.o_overrun_cnt, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
